// File: rtl/c3_pass_scheduler.sv
// ---------------------------------------------------------------------------
// c3_pass_scheduler
//
// Sequences the C3 convolution datapath over its output-channel passes. Each
// processing unit produces two output channels per window, so covering all 16
// C3 channels takes NUM_PASS passes over the buffered 14x14 S2 map. For every
// pass the block:
//   1. requests the weight set for that pass and waits W_LAT cycles for the
//      weights to settle at the PUs,
//   2. raster-scans every OFM_W x OFM_W window origin, issuing one S2 buffer
//      read per accepted window,
//   3. drains and counts the returning results, then moves on to the next pass.
// After the last result of the last pass, done pulses to start the C5 stage.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset, dominates all other inputs
//   start      S2 map fully buffered; only honoured while idle
//   pu_ready   PUs accept a window this cycle; low stalls the scan
//   res_valid  one result pair returned from relu/quant
//   ifm_rd_en  S2 buffer read strobe for the window at (win_row, win_col)
//   win_row    window origin row,    0..OFM_W-1
//   win_col    window origin column, 0..OFM_W-1
//   win_valid  ifm_rd_en delayed by RD_LAT (window data present at the PUs)
//   w_addr     weight-set index, equal to the current pass
//   w_load     one-cycle pulse requesting the weight set at w_addr
//   pass_idx   current pass, 0..NUM_PASS-1
//   busy       high whenever the scheduler is not idle
//   done       one-cycle pulse after the final result of the final pass
//   err        sticky: stray result while idle/loading, or result overflow
//
// Every output comes straight from a flop. Because of that, the window issued
// in a given cycle is decided on the previous clock edge from pu_ready as seen
// there; the first window is decided on the last weight-load cycle so that
// reads start immediately after the weights are stable.
// ---------------------------------------------------------------------------
module c3_pass_scheduler #(
  parameter int OFM_W    = 10,
  parameter int NUM_PASS = 8,
  parameter int W_LAT    = 2,
  parameter int RD_LAT   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pu_ready,
  input  logic       res_valid,
  output logic       ifm_rd_en,
  output logic [3:0] win_row,
  output logic [3:0] win_col,
  output logic       win_valid,
  output logic [2:0] w_addr,
  output logic       w_load,
  output logic [2:0] pass_idx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int WIN_TOTAL = OFM_W * OFM_W;
  localparam int WL_W      = $clog2(W_LAT + 1);

  localparam logic [6:0]      RES_FULL  = 7'(WIN_TOTAL);
  localparam logic [3:0]      LAST_POS  = 4'(OFM_W - 1);
  localparam logic [2:0]      LAST_PASS = 3'(NUM_PASS - 1);
  localparam logic [WL_W-1:0] WL_LAST   = WL_W'(W_LAT);
  localparam logic [WL_W-1:0] WL_FIRST  = WL_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WLOAD,
    ST_SCAN,
    ST_DRAIN
  } state_t;

  state_t          state, state_n;

  // wl_cnt counts the weight-load cycles spent so far (1 on the first one).
  logic [WL_W-1:0] wl_cnt, wl_cnt_n;

  // row_q/col_q hold the next window still to be issued in this pass.
  logic [3:0]      row_q, col_q, row_n, col_n;

  logic [6:0]      res_cnt, res_cnt_n;
  logic [2:0]      pass_n, w_addr_n;
  logic [3:0]      win_row_n, win_col_n;
  logic            rd_en_n, w_load_n, done_n, err_n, busy_n;
  logic            scan_step;
  logic [RD_LAT-1:0] rd_pipe;

  assign win_valid = rd_pipe[RD_LAT-1];

  // Next-state and next-output logic. Result accounting runs first so the
  // drain check below sees a result arriving in the same cycle; that lets
  // the final result move straight on to the next weight load without an
  // extra idle cycle. The window scan is shared between the last weight-load
  // cycle and the scan state, hence the scan_step flag.
  always_comb begin
    state_n   = state;
    wl_cnt_n  = wl_cnt;
    row_n     = row_q;
    col_n     = col_q;
    res_cnt_n = res_cnt;
    pass_n    = pass_idx;
    w_addr_n  = w_addr;
    win_row_n = win_row;
    win_col_n = win_col;
    rd_en_n   = 1'b0;
    w_load_n  = 1'b0;
    done_n    = 1'b0;
    err_n     = err;
    scan_step = 1'b0;

    // Results only make sense while windows are in flight. A result seen
    // while idle or loading weights, or one beyond the full window count,
    // is flagged and dropped.
    if (res_valid) begin
      if ((state == ST_IDLE) || (state == ST_WLOAD) || (res_cnt == RES_FULL)) begin
        err_n = 1'b1;
      end else begin
        res_cnt_n = res_cnt + 7'd1;
      end
    end

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n   = ST_WLOAD;
          wl_cnt_n  = WL_FIRST;
          pass_n    = 3'd0;
          w_addr_n  = 3'd0;
          w_load_n  = 1'b1;
          res_cnt_n = 7'd0;
          row_n     = 4'd0;
          col_n     = 4'd0;
          win_row_n = 4'd0;
          win_col_n = 4'd0;
        end
      end

      ST_WLOAD: begin
        if (wl_cnt == WL_LAST) begin
          scan_step = 1'b1;
        end else begin
          wl_cnt_n = wl_cnt + WL_FIRST;
        end
      end

      ST_SCAN: begin
        scan_step = 1'b1;
      end

      ST_DRAIN: begin
        if (res_cnt_n == RES_FULL) begin
          if (pass_idx == LAST_PASS) begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            state_n   = ST_WLOAD;
            wl_cnt_n  = WL_FIRST;
            pass_n    = pass_idx + 3'd1;
            w_addr_n  = pass_idx + 3'd1;
            w_load_n  = 1'b1;
            res_cnt_n = 7'd0;
            row_n     = 4'd0;
            col_n     = 4'd0;
            win_row_n = 4'd0;
            win_col_n = 4'd0;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // While scanning, the window address outputs always show the pending
    // window, so a stall holds them at the window that is waiting to go.
    if (scan_step) begin
      state_n   = ST_SCAN;
      win_row_n = row_q;
      win_col_n = col_q;
      if (pu_ready) begin
        rd_en_n = 1'b1;
        if (col_q == LAST_POS) begin
          col_n = 4'd0;
          if (row_q == LAST_POS) begin
            state_n = ST_DRAIN;
          end else begin
            row_n = row_q + 4'd1;
          end
        end else begin
          col_n = col_q + 4'd1;
        end
      end
    end

    busy_n = (state_n != ST_IDLE);
  end

  // State and output registers. Reset clears everything, including the
  // sticky error flag, which nothing else clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wl_cnt    <= '0;
      row_q     <= 4'd0;
      col_q     <= 4'd0;
      res_cnt   <= 7'd0;
      pass_idx  <= 3'd0;
      w_addr    <= 3'd0;
      win_row   <= 4'd0;
      win_col   <= 4'd0;
      ifm_rd_en <= 1'b0;
      w_load    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      wl_cnt    <= wl_cnt_n;
      row_q     <= row_n;
      col_q     <= col_n;
      res_cnt   <= res_cnt_n;
      pass_idx  <= pass_n;
      w_addr    <= w_addr_n;
      win_row   <= win_row_n;
      win_col   <= win_col_n;
      ifm_rd_en <= rd_en_n;
      w_load    <= w_load_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

  // Delay line that turns each read strobe into the matching data-valid for
  // the PUs. Reset flushes it so a read issued just before reset never shows
  // up as valid data afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= ifm_rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_c3_pass_scheduler.sv
// ---------------------------------------------------------------------------
// tb_c3_pass_scheduler
//
// Self-checking bench for c3_pass_scheduler. A behavioural model tracks the
// scheduler as "which pass, how many windows issued (linear index), how many
// results back" and predicts every output each cycle; a compare process
// checks the DUT against it on every negative edge. Directed scenarios add
// hand-computed literal expectations (cycle numbers counted from the start
// pulse) that pin down the model itself. A small PU responder returns one
// result five cycles after each win_valid, with hooks to drop or inject one.
// ---------------------------------------------------------------------------
module tb_c3_pass_scheduler;

  localparam int OFM_W    = 10;
  localparam int NUM_PASS = 8;
  localparam int W_LAT    = 2;
  localparam int RD_LAT   = 1;
  localparam int TOTAL    = OFM_W * OFM_W;

  localparam int PH_IDLE  = 0;
  localparam int PH_WLOAD = 1;
  localparam int PH_SCAN  = 2;
  localparam int PH_DRAIN = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pu_ready;
  logic       res_valid;
  logic       ifm_rd_en;
  logic [3:0] win_row;
  logic [3:0] win_col;
  logic       win_valid;
  logic [2:0] w_addr;
  logic       w_load;
  logic [2:0] pass_idx;
  logic       busy;
  logic       done;
  logic       err;

  c3_pass_scheduler #(
    .OFM_W   (OFM_W),
    .NUM_PASS(NUM_PASS),
    .W_LAT   (W_LAT),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pu_ready (pu_ready),
    .res_valid(res_valid),
    .ifm_rd_en(ifm_rd_en),
    .win_row  (win_row),
    .win_col  (win_col),
    .win_valid(win_valid),
    .w_addr   (w_addr),
    .w_load   (w_load),
    .pass_idx (pass_idx),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int         n_total = 0;
  int         n_pass  = 0;
  bit         chk_en  = 1'b0;
  int         drop_cyc   = -1;
  int         inject_cyc = -1;
  logic [5:0] wv_hist = '0;
  int         rd_total   = 0;
  int         done_total = 0;
  logic [2:0] wl_log[$];

  function automatic logic [19:0] pack_outs(input logic rd, input logic [3:0] r,
                                            input logic [3:0] c, input logic wv,
                                            input logic [2:0] wa, input logic wl,
                                            input logic [2:0] pi, input logic b,
                                            input logic d, input logic e);
    return {rd, r, c, wv, wa, wl, pi, b, d, e};
  endfunction

  function automatic logic [19:0] dut_outs();
    return pack_outs(ifm_rd_en, win_row, win_col, win_valid, w_addr, w_load,
                     pass_idx, busy, done, err);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] expv);
    n_total++;
    if (act === expv) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
               name, cyc, act, expv);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_phase = PH_IDLE;
  int         m_wl    = 0;
  int         m_pass  = 0;
  int         m_next  = 0;
  int         m_res   = 0;
  bit         m_err   = 1'b0;
  bit         m_issue;
  bit         m_rd_hist[$];
  logic       e_rd, e_wv, e_wl, e_done;
  logic [3:0] e_row, e_col;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = PH_IDLE;
      m_wl    = 0;
      m_pass  = 0;
      m_next  = 0;
      m_res   = 0;
      m_err   = 1'b0;
      m_rd_hist.delete();
      for (int i = 1; i < RD_LAT; i++) m_rd_hist.push_back(1'b0);
      e_rd   = 1'b0;
      e_wv   = 1'b0;
      e_wl   = 1'b0;
      e_done = 1'b0;
      e_row  = 4'd0;
      e_col  = 4'd0;
    end else begin
      m_rd_hist.push_back(e_rd);
      e_wv    = m_rd_hist.pop_front();
      e_rd    = 1'b0;
      e_wl    = 1'b0;
      e_done  = 1'b0;
      m_issue = 1'b0;
      if (res_valid) begin
        if (m_phase == PH_IDLE || m_phase == PH_WLOAD || m_res == TOTAL) m_err = 1'b1;
        else m_res++;
      end
      case (m_phase)
        PH_IDLE: if (start) begin
          m_phase = PH_WLOAD; m_wl = 1; m_pass = 0; m_res = 0; m_next = 0;
          e_wl = 1'b1; e_row = 4'd0; e_col = 4'd0;
        end
        PH_WLOAD: if (m_wl == W_LAT) m_issue = 1'b1; else m_wl++;
        PH_SCAN:  m_issue = 1'b1;
        default: if (m_res == TOTAL) begin
          if (m_pass == NUM_PASS - 1) begin
            e_done = 1'b1; m_phase = PH_IDLE;
          end else begin
            m_pass++; m_res = 0; m_next = 0; m_wl = 1; m_phase = PH_WLOAD;
            e_wl = 1'b1; e_row = 4'd0; e_col = 4'd0;
          end
        end
      endcase
      if (m_issue) begin
        m_phase = PH_SCAN;
        e_row   = 4'(m_next / OFM_W);
        e_col   = 4'(m_next % OFM_W);
        if (pu_ready) begin
          e_rd = 1'b1;
          m_next++;
          if (m_next == TOTAL) m_phase = PH_DRAIN;
        end
      end
    end
  end

  // Per-cycle compare plus the monitors used by the directed checks.
  always @(negedge clk) begin
    if (rst) wv_hist = '0;
    else     wv_hist = {wv_hist[4:0], win_valid};
    if (chk_en) begin
      check_output("cycle_outputs", 32'(dut_outs()),
                   32'(pack_outs(e_rd, e_row, e_col, e_wv, 3'(m_pass), e_wl,
                                 3'(m_pass), logic'(m_phase != PH_IDLE), e_done, m_err)));
      if (ifm_rd_en) rd_total++;
      if (done) done_total++;
      if (w_load) wl_log.push_back(w_addr);
    end
  end

  // PU responder: one result five cycles after each win_valid.
  always @(posedge clk) begin
    #1;
    res_valid = (wv_hist[4] && (cyc != drop_cyc)) || (cyc == inject_cyc);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) tick();
  endtask

  task automatic clear_counters();
    rd_total   = 0;
    done_total = 0;
    wl_log.delete();
  endtask

  task automatic apply_stimulus(output int t0);
    tick();
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_total == 0 && n < budget) begin
      tick();
      n++;
    end
    check_output("done_within_budget", 32'(done_total), 32'd1);
    repeat (10) tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t0;
    rst = 1'b1; start = 1'b0; pu_ready = 1'b1; res_valid = 1'b0;

    // Reset held three cycles with a start pulse inside it.
    @(posedge clk); #1;
    chk_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0; tick();
    @(negedge clk);
    check_output("reset_all_zero", 32'(dut_outs()), 32'd0);
    rst = 1'b0;
    tick(); tick();
    @(negedge clk);
    check_output("start_in_reset_ignored", 32'(busy), 32'd0);

    // Full run, pu_ready always high.
    $display("[TB] full run");
    clear_counters();
    apply_stimulus(t0);
    at_cycle(t0 + 1);   @(negedge clk);
    check_output("first_wload", 32'({w_load, w_addr, busy}), 32'({1'b1, 3'd0, 1'b1}));
    at_cycle(t0 + 3);   @(negedge clk);
    check_output("first_read_00", 32'({ifm_rd_en, win_row, win_col, win_valid}),
                 32'({1'b1, 4'd0, 4'd0, 1'b0}));
    at_cycle(t0 + 4);   @(negedge clk);
    check_output("first_win_valid", 32'({win_valid, win_row, win_col}), 32'({1'b1, 4'd0, 4'd1}));
    at_cycle(t0 + 102); @(negedge clk);
    check_output("last_read_99", 32'({ifm_rd_en, win_row, win_col, pass_idx}),
                 32'({1'b1, 4'd9, 4'd9, 3'd0}));
    at_cycle(t0 + 103); @(negedge clk);
    check_output("scan_stops", 32'({ifm_rd_en, busy}), 32'({1'b0, 1'b1}));
    at_cycle(t0 + 109); @(negedge clk);
    check_output("pass1_wload", 32'({w_load, w_addr}), 32'({1'b1, 3'd1}));
    wait_done(2000);
    check_output("total_reads", 32'(rd_total), 32'd800);
    check_output("done_pulses", 32'(done_total), 32'd1);
    check_output("wload_count", 32'(wl_log.size()), 32'(NUM_PASS));
    for (int i = 0; i < wl_log.size(); i++) check_output("w_addr_step", 32'(wl_log[i]), 32'(i));
    check_output("run_end_state", 32'({err, busy}), 32'd0);

    // Stall at (3,7) and withhold the last pass-0 result.
    $display("[TB] stall and drain run");
    clear_counters();
    apply_stimulus(t0);
    drop_cyc   = t0 + 112;
    inject_cyc = t0 + 125;
    at_cycle(t0 + 39);
    pu_ready = 1'b0;
    @(negedge clk);
    check_output("pre_stall_36", 32'({ifm_rd_en, win_row, win_col}), 32'({1'b1, 4'd3, 4'd6}));
    for (int k = 40; k <= 43; k++) begin
      at_cycle(t0 + k);
      if (k == 43) pu_ready = 1'b1;
      @(negedge clk);
      check_output("stall_hold_37", 32'({ifm_rd_en, win_row, win_col}), 32'({1'b0, 4'd3, 4'd7}));
    end
    at_cycle(t0 + 44); @(negedge clk);
    check_output("resume_37", 32'({ifm_rd_en, win_row, win_col}), 32'({1'b1, 4'd3, 4'd7}));
    at_cycle(t0 + 106); @(negedge clk);
    check_output("stalled_last_read", 32'({ifm_rd_en, win_row, win_col}), 32'({1'b1, 4'd9, 4'd9}));
    for (int k = 113; k <= 125; k++) begin
      at_cycle(t0 + k); @(negedge clk);
      check_output("drain_wait", 32'({busy, w_load}), 32'({1'b1, 1'b0}));
    end
    check_output("pass0_reads", 32'(rd_total), 32'd100);
    at_cycle(t0 + 126); @(negedge clk);
    check_output("late_result_wload", 32'({w_load, w_addr}), 32'({1'b1, 3'd1}));
    wait_done(2000);
    check_output("stall_run_err", 32'(err), 32'd0);

    // Stray result while idle, then a full run with err sticky.
    $display("[TB] idle error run");
    inject_cyc = cyc + 3;
    at_cycle(inject_cyc + 1); @(negedge clk);
    check_output("idle_result_err", 32'({err, busy}), 32'({1'b1, 1'b0}));
    clear_counters();
    apply_stimulus(t0);
    wait_done(2000);
    check_output("err_sticky_after_run", 32'({err, busy}), 32'({1'b1, 1'b0}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_output("err_cleared_by_rst", 32'(err), 32'd0);

    // Reset during pass 3 at window (5,2).
    $display("[TB] mid-scan reset run");
    clear_counters();
    apply_stimulus(t0);
    at_cycle(t0 + 379);
    rst = 1'b1;
    @(negedge clk);
    check_output("pass3_read_52", 32'({ifm_rd_en, win_row, win_col, pass_idx}),
                 32'({1'b1, 4'd5, 4'd2, 3'd3}));
    at_cycle(t0 + 380);
    rst = 1'b0;
    rd_total = 0;
    @(negedge clk);
    check_output("mid_reset_all_zero", 32'(dut_outs()), 32'd0);
    at_cycle(t0 + 386); @(negedge clk);
    check_output("no_reads_after_reset", 32'({rd_total, busy, done_total}), 32'd0);
    apply_stimulus(t0);
    at_cycle(t0 + 1); @(negedge clk);
    check_output("restart_wload", 32'({w_load, w_addr, pass_idx}), 32'({1'b1, 3'd0, 3'd0}));
    at_cycle(t0 + 3); @(negedge clk);
    check_output("restart_read_00", 32'({ifm_rd_en, win_row, win_col, pass_idx}),
                 32'({1'b1, 4'd0, 4'd0, 3'd0}));
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
